// File: rtl/c17_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// c17_share_ctrl_if
// Request/response handshake bundle between the two stimulus agents and the
// c17 sharing controller.
//   req0_valid/req0_vec/req0_ready : requester 0 vector handshake
//   req1_valid/req1_vec/req1_ready : requester 1 vector handshake
//   rsp0_valid/rsp0_data           : one-cycle result pulse for requester 0
//   rsp1_valid/rsp1_data           : one-cycle result pulse for requester 1
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface c17_share_ctrl_if;
    logic       req0_valid;
    logic [4:0] req0_vec;
    logic       req0_ready;
    logic       req1_valid;
    logic [4:0] req1_vec;
    logic       req1_ready;
    logic       rsp0_valid;
    logic [1:0] rsp0_data;
    logic       rsp1_valid;
    logic [1:0] rsp1_data;

    modport master (
        output req0_valid, req0_vec, req1_valid, req1_vec,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );

    modport slave (
        input  req0_valid, req0_vec, req1_valid, req1_vec,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/c17_share_ctrl.sv
// ---------------------------------------------------------------------------
// c17_share_ctrl
// Time-shares one clocked c17 core between two requesters. After reset (or a
// soft clear) the core's input flops are held in sync reset for INIT_CYCLES
// cycles, then vectors are accepted round-robin at one per cycle. Each result
// returns to its issuer exactly two edges after the accept.
// Ports:
//   clk            : rising-edge clock (block and c17 core)
//   async_reset_n  : asynchronous active-low reset
//   soft_clear     : synchronous request to re-run the clear sequence
//   bus            : request/response handshakes (slave modport)
//   c17_in         : vector to the c17 core {N7,N6,N3,N2,N1}
//   c17_sync_reset : sync reset to the c17 core
//   c17_out        : c17 core result {N23,N22}
//   grant0_cnt/grant1_cnt : accepted-request counters (wrap)
//   busy           : high in INIT or while a result is in flight
// ---------------------------------------------------------------------------
module c17_share_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic             soft_clear,
    c17_share_ctrl_if.slave  bus,
    output logic [4:0]       c17_in,
    output logic             c17_sync_reset,
    input  logic [1:0]       c17_out,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt,
    output logic             busy
);

    localparam int ICW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);
    localparam logic [ICW-1:0] INIT_LOAD = ICW'(INIT_CYCLES);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t         state_reg, state_next;
    logic [ICW-1:0] init_cnt_reg, init_cnt_next;

    logic             run;
    logic [1:0]       req_valid;
    logic [4:0]       req_vec [2];
    logic [1:0]       ready;
    logic [1:0]       accept;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_data_reg [2];
    logic [CNT_W-1:0] grant_cnt_reg [2];

    logic last_grant_reg;
    logic s1_valid_reg, s1_id_reg;
    logic s2_valid_reg, s2_id_reg;

    assign req_valid  = {bus.req1_valid, bus.req0_valid};
    assign req_vec[0] = bus.req0_vec;
    assign req_vec[1] = bus.req1_vec;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= INIT_LOAD;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                if (soft_clear) begin
                    init_cnt_next = INIT_LOAD;
                end else if (init_cnt_reg <= ICW'(1)) begin
                    state_next = ST_RUN;
                end else begin
                    init_cnt_next = init_cnt_reg - ICW'(1);
                end
            end
            ST_RUN: begin
                if (soft_clear) begin
                    state_next    = ST_INIT;
                    init_cnt_next = INIT_LOAD;
                end
            end
            default: begin
                state_next    = ST_INIT;
                init_cnt_next = INIT_LOAD;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Under contention the requester that did not win last time is served;
    // a lone requester is always served. soft_clear blocks all grants so no
    // vector is accepted in the cycle the pipeline is being flushed.
    always_comb begin
        run    = (state_reg == ST_RUN);
        ready  = 2'b00;
        c17_in = 5'b00000;
        if (run && !soft_clear) begin
            ready[0] = req_valid[0] && (!req_valid[1] || last_grant_reg);
            ready[1] = req_valid[1] && (!req_valid[0] || !last_grant_reg);
        end
        accept = ready & req_valid;
        if (accept[0]) begin
            c17_in = req_vec[0];
        end else if (accept[1]) begin
            c17_in = req_vec[1];
        end
        c17_sync_reset = !run;
        busy           = !run || s1_valid_reg || s2_valid_reg;
    end

    // ---------------- Tag pipeline and arbitration memory ----------------
    // Stage 1 marks the cycle the core output is valid for the accepted
    // vector; stage 2 marks the cycle the registered response is presented.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            last_grant_reg <= 1'b1;
            s1_valid_reg   <= 1'b0;
            s1_id_reg      <= 1'b0;
            s2_valid_reg   <= 1'b0;
            s2_id_reg      <= 1'b0;
        end else begin
            if (accept != 2'b00) begin
                last_grant_reg <= accept[1];
            end
            s1_valid_reg <= (accept != 2'b00);
            s1_id_reg    <= accept[1];
            s2_valid_reg <= s1_valid_reg && !soft_clear;
            s2_id_reg    <= s1_id_reg;
        end
    end

    // ---------------- Per-requester response and grant counter ----------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            always_ff @(posedge clk or negedge async_reset_n) begin
                if (!async_reset_n) begin
                    rsp_data_reg[gi]  <= 2'b00;
                    grant_cnt_reg[gi] <= '0;
                end else begin
                    // A flushed result must not overwrite the last good data.
                    if (s1_valid_reg && !soft_clear && (s1_id_reg == 1'(gi))) begin
                        rsp_data_reg[gi] <= c17_out;
                    end
                    if (accept[gi]) begin
                        grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 1'b1;
                    end
                end
            end
            assign rsp_valid[gi] = s2_valid_reg && (s2_id_reg == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp1_valid = rsp_valid[1];
    assign bus.rsp0_data  = rsp_data_reg[0];
    assign bus.rsp1_data  = rsp_data_reg[1];
    assign grant0_cnt     = grant_cnt_reg[0];
    assign grant1_cnt     = grant_cnt_reg[1];

endmodule

// File: tb/tb_c17_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_c17_share_ctrl
// Directed bench for c17_share_ctrl with a behavioural clocked c17 core.
// ---------------------------------------------------------------------------
module tb_c17_share_ctrl;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             async_reset_n;
    logic             soft_clear;
    logic [4:0]       c17_in;
    logic             c17_sync_reset;
    logic [1:0]       c17_out;
    logic [CNT_W-1:0] grant0_cnt, grant1_cnt;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_g0  = 0;

    c17_share_ctrl_if bus ();

    c17_share_ctrl #(.INIT_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .async_reset_n  (async_reset_n),
        .soft_clear     (soft_clear),
        .bus            (bus.slave),
        .c17_in         (c17_in),
        .c17_sync_reset (c17_sync_reset),
        .c17_out        (c17_out),
        .grant0_cnt     (grant0_cnt),
        .grant1_cnt     (grant1_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // c17 gate netlist, bit order {N7,N6,N3,N2,N1} in, {N23,N22} out
    function automatic logic [1:0] c17f(input logic [4:0] v);
        logic n10, n11, n16, n19;
        n10 = ~(v[0] & v[2]);
        n11 = ~(v[2] & v[3]);
        n16 = ~(v[1] & n11);
        n19 = ~(n11 & v[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    // Clocked c17 core model: input flops with synchronous clear.
    logic [4:0] core_q = 5'b0;
    always @(posedge clk) begin
        if (c17_sync_reset) core_q <= 5'b0;
        else                core_q <= c17_in;
    end
    assign c17_out = c17f(core_q);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] tv0 [6] = '{5'b00101, 5'b11011, 5'b10000, 5'b01010, 5'b11111, 5'b10100};
    logic [4:0] tv1 [6] = '{5'b01110, 5'b10000, 5'b00011, 5'b10101, 5'b00110, 5'b11001};
    logic [4:0] sv  [5] = '{5'b00101, 5'b11111, 5'b10000, 5'b01110, 5'b00000};
    logic [1:0] sd  [5] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00};

    initial begin
        // ---------------- reset ----------------
        async_reset_n  = 1'b0;
        soft_clear     = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_vec   = 5'b00101;
        bus.req1_valid = 1'b0;
        bus.req1_vec   = 5'b00000;
        #2;
        chk("rst_ready0", bus.req0_ready, 1'b0);
        chk("rst_ready1", bus.req1_ready, 1'b0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
        chk("rst_rsp0_data", bus.rsp0_data, 2'b00);
        chk("rst_c17_in", c17_in, 5'b0);
        chk("rst_sync_reset", c17_sync_reset, 1'b1);
        chk("rst_busy", busy, 1'b1);
        chk("rst_grant0", grant0_cnt, 0);
        chk("rst_grant1", grant1_cnt, 0);
        tick();
        tick();
        async_reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("init_ready0", bus.req0_ready, 1'b0);
            chk("init_sync_reset", c17_sync_reset, 1'b1);
            chk("init_rsp0_valid", bus.rsp0_valid, 1'b0);
            tick();
        end

        // ---------------- contention: both valid 6 cycles ----------------
        for (int i = 0; i < 8; i++) begin
            bus.req0_valid = (i < 6);
            bus.req1_valid = (i < 6);
            bus.req0_vec   = tv0[i % 6];
            bus.req1_vec   = tv1[i % 6];
            #1;
            if (i < 6) begin
                chk("arb_ready0", bus.req0_ready, (i % 2) == 0);
                chk("arb_ready1", bus.req1_ready, (i % 2) == 1);
                chk("arb_c17_in", c17_in, ((i % 2) == 1) ? tv1[i] : tv0[i]);
                chk("arb_sync_reset", c17_sync_reset, 1'b0);
            end
            if (i >= 2) begin
                chk("arb_rsp0_valid", bus.rsp0_valid, ((i - 2) % 2) == 0);
                chk("arb_rsp1_valid", bus.rsp1_valid, ((i - 2) % 2) == 1);
                if (((i - 2) % 2) == 0) chk("arb_rsp0_data", bus.rsp0_data, c17f(tv0[i - 2]));
                else                    chk("arb_rsp1_data", bus.rsp1_data, c17f(tv1[i - 2]));
            end
            tick();
        end
        chk("arb_grant0", grant0_cnt, 3);
        chk("arb_grant1", grant1_cnt, 3);
        exp_g0 = 3;

        // ---------------- requester 0 only ----------------
        for (int i = 0; i < 8; i++) begin
            bus.req0_valid = (i < 5);
            bus.req0_vec   = sv[i % 5];
            #1;
            if (i < 5) begin
                chk("solo_ready0", bus.req0_ready, 1'b1);
                chk("solo_c17_in", c17_in, sv[i]);
            end
            chk("solo_rsp1_valid", bus.rsp1_valid, 1'b0);
            if (i >= 2 && i < 7) begin
                chk("solo_rsp0_valid", bus.rsp0_valid, 1'b1);
                chk("solo_rsp0_data", bus.rsp0_data, sd[i - 2]);
            end
            if (i == 6) chk("solo_busy_inflight", busy, 1'b1);
            if (i == 7) begin
                chk("solo_rsp0_idle", bus.rsp0_valid, 1'b0);
                chk("solo_busy_idle", busy, 1'b0);
            end
            tick();
        end
        exp_g0 = exp_g0 + 5;
        chk("solo_grant0", grant0_cnt, 32'(exp_g0));
        chk("solo_grant1", grant1_cnt, 3);

        // ---------------- soft clear after an accept ----------------
        bus.req0_valid = 1'b1;
        bus.req0_vec   = 5'b10000;
        #1;
        chk("sc_accept_ready0", bus.req0_ready, 1'b1);
        tick();
        exp_g0 = exp_g0 + 1;
        soft_clear = 1'b1;
        #1;
        chk("sc_ready0_blocked", bus.req0_ready, 1'b0);
        chk("sc_busy", busy, 1'b1);
        tick();
        soft_clear = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("sc_init_ready0", bus.req0_ready, 1'b0);
            chk("sc_init_sync_reset", c17_sync_reset, 1'b1);
            chk("sc_no_rsp0", bus.rsp0_valid, 1'b0);
            tick();
        end
        #1;
        chk("sc_resume_ready0", bus.req0_ready, 1'b1);
        chk("sc_resume_sync", c17_sync_reset, 1'b0);
        chk("sc_grant0_kept", grant0_cnt, 32'(exp_g0));
        chk("sc_grant1_kept", grant1_cnt, 3);
        chk("sc_no_rsp0_late", bus.rsp0_valid, 1'b0);
        tick();
        exp_g0 = exp_g0 + 1;

        // ---------------- grant counter wrap ----------------
        for (int k = exp_g0; k < 15; k++) tick();
        exp_g0 = 15;
        #1;
        chk("wrap_grant0_max", grant0_cnt, 15);
        tick();
        exp_g0 = 0;
        #1;
        chk("wrap_grant0_zero", grant0_cnt, 32'(exp_g0));
        chk("wrap_busy_inflight", busy, 1'b1);

        // ---------------- async reset with two results in flight ----------------
        async_reset_n = 1'b0;
        #1;
        chk("ar_ready0", bus.req0_ready, 1'b0);
        chk("ar_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk("ar_rsp0_data", bus.rsp0_data, 2'b00);
        chk("ar_sync_reset", c17_sync_reset, 1'b1);
        chk("ar_c17_in", c17_in, 5'b0);
        chk("ar_busy", busy, 1'b1);
        chk("ar_grant0", grant0_cnt, 0);
        chk("ar_grant1", grant1_cnt, 0);
        tick();
        async_reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("ar_init_ready0", bus.req0_ready, 1'b0);
            chk("ar_init_sync", c17_sync_reset, 1'b1);
            chk("ar_init_no_rsp0", bus.rsp0_valid, 1'b0);
            tick();
        end
        #1;
        chk("ar_run_ready0", bus.req0_ready, 1'b1);
        chk("ar_run_sync", c17_sync_reset, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("ar_run_no_rsp_yet", bus.rsp0_valid, 1'b0);
        chk("ar_run_grant0", grant0_cnt, 1);
        tick();
        #1;
        chk("ar_run_rsp0_valid", bus.rsp0_valid, 1'b1);
        chk("ar_run_rsp0_data", bus.rsp0_data, 2'b10);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/c17_share_ctrl.md
# c17_share_ctrl

Controller that time-shares a single clocked c17 datapath instance between two requesters. It runs a post-reset clear sequence on the datapath flops, then arbitrates requests round-robin at one vector per cycle. Each result is returned to the requester that issued it, with fixed latency. The block sits between the test/stimulus agents and the clocked c17 core in the trojan-evaluation harness.

## Interface
Parameters:
- INIT_CYCLES, 2, number of cycles c17_sync_reset is held high after reset or soft clear (>=1)
- CNT_W, 16, width of per-requester grant counters

Ports:
- clk  in  1  rising-edge clock for the block and the c17 core
- async_reset_n  in  1  asynchronous, active-low reset
- soft_clear  in  1  synchronous request to re-run the clear sequence
- req0_valid  in  1  requester 0 has a vector
- req0_vec  in  5  requester 0 vector: bit0=N1, bit1=N2, bit2=N3, bit3=N6, bit4=N7
- req0_ready  out  1  requester 0 vector accepted this cycle
- req1_valid / req1_vec / req1_ready  same as requester 0
- rsp0_valid  out  1  one-cycle pulse, result for requester 0
- rsp0_data  out  2  {N23,N22}
- rsp1_valid / rsp1_data  same as rsp0
- c17_in  out  5  to c17 core N1,N2,N3,N6,N7 (same bit order as reqN_vec)
- c17_sync_reset  out  1  to c17 core sync_reset
- c17_out  in  2  from c17 core {N23,N22}
- grant0_cnt, grant1_cnt  out  CNT_W  accepted-request counters, wrap modulo 2^CNT_W
- busy  out  1  high in INIT or while any result is in flight

## Operation
- FSM states: INIT and RUN.
- async_reset_n low: state=INIT, init counter=INIT_CYCLES, last_grant=1 (requester 0 wins first), in-flight valids=0, grant counters=0.
- Reset values of outputs: reqN_ready=0, rspN_valid=0, rspN_data=0, c17_in=0, c17_sync_reset=1, busy=1.
- INIT: c17_sync_reset=1, c17_in=0, both ready=0. Counter decrements each cycle; at 1 → RUN next edge.
- RUN: c17_sync_reset=0.
  - A request is accepted when reqN_valid & reqN_ready.
  - ready is combinational and never asserted while soft_clear=1.
  - One valid requester: it gets ready.
  - Both valid: the requester other than last_grant gets ready. last_grant updates only on an accept.
  - The accepted vector drives c17_in combinationally in the same cycle. With no accept, c17_in=0.
- Each accept increments that requester's grant counter and enters a 2-stage tag pipeline {valid, id}.
- Stage-2 valid: c17_out is registered into rspN_data and rspN_valid pulses for the tagged id. rsp data of the other requester holds its previous value.
- soft_clear=1 in RUN: next edge → INIT, counter reloaded, all in-flight valids cleared (results dropped, no rsp pulse), grant counters kept, last_grant kept. soft_clear in INIT reloads the counter.
- No response backpressure; requesters must accept rsp pulses.

## Timing
- Accept at edge k: c17 core flops capture c17_in at edge k, c17_out settles in cycle k..k+1, response registered at edge k+1, rspN_valid high for the cycle after edge k+1. Latency is 2 edges from accept.
- Throughput is 1 accept per cycle, alternating between requesters under contention.
- First RUN cycle (ready possible) is INIT_CYCLES cycles after async_reset_n deasserts.
- Reset asserted mid-operation: outputs take reset values immediately (asynchronous), and in-flight results are lost.
- busy=0 only in RUN with both pipeline stages empty.

## Test plan
- Reset, INIT_CYCLES=2 → ready=0 and c17_sync_reset=1 for 2 cycles, then RUN. No rsp pulses; grant counters 0.
- Requester 0 only, vectors 5'b00101, 5'b11111, 5'b10000, 5'b01110, 5'b00000 on consecutive cycles → rsp0_data 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, each 2 edges after accept; rsp1_valid never set.
- Both valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1. grant0_cnt=3, grant1_cnt=3, and each rsp returns to the correct requester.
- soft_clear asserted one cycle after an accept → no rsp pulse for that vector, ready=0 for INIT_CYCLES+1 cycles, then service resumes and counters are retained.
- Grant counter at 2^CNT_W-1 plus one accept → counter reads 0.
- async_reset_n pulsed low while two results are in flight → immediate reset values, no rsp pulses afterwards, and the full INIT sequence runs again.
